change_monitor: RTL and testbench
=================================

// Module: change_monitor
// PURPOSE
//  Hardware counterpart of a $monitor line: it observes three 1-bit signals a, b, c.
//  It forms x = a|b|c combinationally and emits a timestamped event record whenever any of {a,b,c,x} changes.
//  It always emits one record on the first cycle after reset, mirroring always_comb time-zero evaluation.
//  Downstream logic (trace buffer, UART logger) drains records through a valid/ready port.
// PARAMETERS
//  TS_W   16  width of free-running cycle timestamp (wraps modulo 2**TS_W)
//  DEPTH  4   event FIFO depth; power of 2, >=2
//  CNT_W  8   width of dropped-event counter (saturating)
// PORTS
//  clk          in   1          single clock, rising edge
//  rst          in   1          synchronous, active-high reset
//  a_i,b_i,c_i  in   1 each     observed signals, sampled every rising edge
//  x_o          out  1          a_i|b_i|c_i, purely combinational (always_comb)
//  evt_valid_o  out  1          FIFO head holds a record
//  evt_ready_i  in   1          consumer accepts head when evt_valid_o&evt_ready_i
//  evt_data_o   out  TS_W+4     {ts[TS_W-1:0], a, b, c, x} of FIFO head
//  drop_cnt_o   out  CNT_W      records lost to full FIFO, saturates at all-ones
//  overflow_o   out  1          sticky: set on first drop, cleared only by rst
// BEHAVIOUR
//  Reset (rst=1 at an edge) forces the following state:
//  - ts=0, prev={a,b,c,x}=0, FIFO empty, evt_valid_o=0, evt_data_o=0 (head mem don't-care, driven 0 when empty).
//  - drop_cnt_o=0, overflow_o=0, state=S_INIT.
//  - x_o still follows the inputs during reset.
//  Timestamp: ts increments by 1 every non-reset edge and wraps to 0 after 2**TS_W-1.
//  FSM: S_INIT, S_RUN.
//  - S_INIT: first non-reset edge; push {ts,cur} unconditionally, ->S_RUN.
//  - S_RUN: at each edge compare cur={a_i,b_i,c_i,x_o} with prev; push {ts,cur} iff cur!=prev. prev<=cur every edge.
//  The recorded ts is the value before that edge's increment.
//  Latency: a change sampled at edge k sets evt_valid_o after edge k. The FIFO is first-word-fallthrough: head data is valid with valid.
//  Handshake: evt_data_o is stable while evt_valid_o=1 and evt_ready_i=0. Pop on valid&ready. Records leave in push order.
//  Full/empty rules:
//  - Push with FIFO full and no pop in the same cycle: drop the record; drop_cnt_o+=1 (saturating); overflow_o<=1.
//  - Push with FIFO full and a pop in the same cycle: accept, no drop, count unchanged.
//  - Pop with FIFO empty: ignored, since evt_valid_o=0.
//  - Push with FIFO empty: valid rises next cycle. No same-cycle bypass.
//  Reset mid-operation: queued records are discarded; the next non-reset edge emits a fresh S_INIT record with ts=0.
//  Widths: the FIFO count is $clog2(DEPTH)+1 bits; pointers wrap naturally.
// STRUCTURE
//  change_monitor_pkg:
//  - typedef enum logic {S_INIT,S_RUN} mon_state_t
//  - typedef struct packed {logic[TS_W-1:0] ts; logic a,b,c,x;} evt_t, parameterised via a package localparam TS_W_DEF=16
//  Sub-module sync_fifo #(WIDTH,DEPTH): clk, rst, push, pop, wdata, rdata, full, empty.
//  - FWFT, synchronous active-high reset.
//  - Top level owns the FSM, ts counter, compare, drop logic.
// TESTING
//  1 Reset 3 cycles, inputs 0, ready=1 -> exactly one record {ts=0,0,0,0,0}; no further records over 20 cycles.
//  2 a=1 before edge ts=10, b=1 before ts=20, c=1 before ts=30, ready=1 ->
//    records {10,1,0,0,1}, {20,1,1,0,1}, {30,1,1,1,1}; x_o=1 combinationally right after a rises.
//  3 DEPTH=4, ready=0 from reset, toggle a at ts=1..5 ->
//    FIFO holds init record + ts 1,2,3; drop_cnt_o=2; overflow_o=1.
//    Then ready=1 drains 4 records in order, and evt_valid_o=0 after the 4th.
//  4 FIFO full, change and valid&ready in same cycle -> record accepted; drop_cnt_o unchanged; count stays DEPTH.
//  5 3 records queued, pulse rst for 1 cycle -> evt_valid_o=0 after reset edge.
//    Next record is {ts=0,cur}; drop_cnt_o=0; overflow_o=0.
//  6 TS_W=4, toggle c at ts=15 and at the next edge -> records with ts=15 then ts=0 (wrap).

Source files
------------

// File: rtl/change_monitor_pkg.sv
// Shared types and default sizes for the change monitor.
package change_monitor_pkg;

   localparam int TS_W_DEF  = 16;
   localparam int DEPTH_DEF = 4;
   localparam int CNT_W_DEF = 8;

   typedef enum logic {S_INIT, S_RUN} mon_state_t;

   // Event record layout at the default timestamp width; MSB-first matches evt_data_o.
   typedef struct packed {
      logic [TS_W_DEF-1:0] ts;
      logic                a;
      logic                b;
      logic                c;
      logic                x;
   } evt_t;

endpackage

// File: rtl/sync_fifo.sv
// First-word-fallthrough synchronous FIFO. A push while full is accepted only
// when a pop happens in the same cycle; a pop while empty is ignored.
module sync_fifo #(
   parameter int WIDTH = 20,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wptr;
   logic [AW-1:0]    rptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   // Qualify requests against occupancy; head slot may be reused when full and popping.
   always_comb begin
      full    = (count == (AW+1)'(DEPTH));
      empty   = (count == '0);
      do_pop  = pop & ~empty;
      do_push = push & (~full | do_pop);
      rdata   = empty ? '0 : mem[rptr];
   end

   // Storage array; contents are don't-care until written.
   always_ff @(posedge clk) begin
      if (do_push) mem[wptr] <= wdata;
   end

   // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy.
   always_ff @(posedge clk) begin
      if (rst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (do_push) wptr <= wptr + 1'b1;
         if (do_pop)  rptr <= rptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/change_monitor.sv
// Observes a/b/c, derives x=a|b|c and queues a timestamped record whenever any
// of {a,b,c,x} changes, plus one unconditional record right after reset.
// Handshake: a record transfers on a cycle where evt_valid_o and evt_ready_i
// are both high at the rising edge; evt_data_o holds steady while valid waits.
module change_monitor
   import change_monitor_pkg::*;
#(
   parameter int TS_W  = TS_W_DEF,
   parameter int DEPTH = DEPTH_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              a_i,
   input  logic              b_i,
   input  logic              c_i,
   output logic              x_o,
   output logic              evt_valid_o,
   input  logic              evt_ready_i,
   output logic [TS_W+3:0]   evt_data_o,
   output logic [CNT_W-1:0]  drop_cnt_o,
   output logic              overflow_o,
   output mon_state_t        dbg_state
);

   mon_state_t      state;
   mon_state_t      state_next;
   logic [TS_W-1:0] ts;
   logic [3:0]      prev;
   logic [3:0]      cur;
   logic            push_req;
   logic            pop;
   logic            full;
   logic            empty;
   logic            drop;

   // Observed OR term; follows the inputs even while in reset.
   always_comb begin
      x_o = a_i | b_i | c_i;
   end

   // Next-state and push decision: first cycle always records, then only on change.
   always_comb begin
      state_next = state;
      push_req   = 1'b0;
      cur        = {a_i, b_i, c_i, x_o};
      case (state)
         S_INIT: begin
            push_req   = 1'b1;
            state_next = S_RUN;
         end
         S_RUN: begin
            push_req = (cur != prev);
         end
         default: state_next = S_INIT;
      endcase
   end

   // Handshake and drop detection; a full FIFO still accepts if its head leaves now.
   always_comb begin
      evt_valid_o = ~empty;
      pop         = evt_valid_o & evt_ready_i;
      drop        = push_req & full & ~pop;
      dbg_state   = state;
   end

   // FSM, timestamp, previous sample and drop bookkeeping.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_INIT;
         ts         <= '0;
         prev       <= '0;
         drop_cnt_o <= '0;
         overflow_o <= 1'b0;
      end else begin
         state <= state_next;
         ts    <= ts + 1'b1;
         prev  <= cur;
         if (drop) begin
            overflow_o <= 1'b1;
            if (drop_cnt_o != '1) drop_cnt_o <= drop_cnt_o + 1'b1;
         end
      end
   end

   sync_fifo #(
      .WIDTH (TS_W + 4),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_req),
      .pop   (pop),
      .wdata ({ts, cur}),
      .rdata (evt_data_o),
      .full  (full),
      .empty (empty)
   );

endmodule

// File: tb/tb_change_monitor.sv
// Bench for change_monitor: directed scenarios plus random traffic against a
// queue-based reference model of the event stream.
module tb_change_monitor;
   import change_monitor_pkg::*;

   localparam int TS_W  = 16;
   localparam int DEPTH = 4;
   localparam int CNT_W = 8;
   localparam int DW    = TS_W + 4;
   localparam int DW4   = 8;

   // clock / reset block
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst = 1'b1;
   logic             a = 1'b0, b = 1'b0, c = 1'b0, ready = 1'b0;
   logic             x, valid, overflow;
   logic [DW-1:0]    data;
   logic [CNT_W-1:0] drop_cnt;
   mon_state_t       st;

   logic             rst4 = 1'b1, c4 = 1'b0, zero = 1'b0, ready4 = 1'b1;
   logic             x4, valid4, ovf4;
   logic [DW4-1:0]   data4;
   logic [CNT_W-1:0] drop4;
   mon_state_t       st4;

   change_monitor #(.TS_W(TS_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .a_i(a), .b_i(b), .c_i(c), .x_o(x),
      .evt_valid_o(valid), .evt_ready_i(ready), .evt_data_o(data),
      .drop_cnt_o(drop_cnt), .overflow_o(overflow), .dbg_state(st)
   );

   change_monitor #(.TS_W(4), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut4 (
      .clk(clk), .rst(rst4), .a_i(zero), .b_i(zero), .c_i(c4), .x_o(x4),
      .evt_valid_o(valid4), .evt_ready_i(ready4), .evt_data_o(data4),
      .drop_cnt_o(drop4), .overflow_o(ovf4), .dbg_state(st4)
   );

   // scoreboard / reference model state
   logic [DW-1:0]  exp_q[$];
   logic [DW-1:0]  log_q[$];
   logic [DW4-1:0] log4_q[$];
   int             m_ts = 0;
   logic [3:0]     m_prev = '0;
   bit             m_first = 1'b1;
   int             m_drops = 0;
   bit             m_ovf = 1'b0;
   bit             armed = 1'b0;
   int             tests_run = 0;
   int             tests_failed = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [DW-1:0] mk(input int t, input logic aa, input logic bb, input logic cc);
      logic [TS_W-1:0] tt;
      tt = t[TS_W-1:0];
      return {tt, aa, bb, cc, aa | bb | cc};
   endfunction

   function automatic logic [DW4-1:0] mk4(input int t, input logic cc);
      logic [3:0] tt;
      tt = t[3:0];
      return {tt, 1'b0, 1'b0, cc, cc};
   endfunction

   function automatic logic [31:0] log_at(input int idx);
      return (idx < log_q.size()) ? 32'(log_q[idx]) : 32'hFFFF_FFFF;
   endfunction

   function automatic logic [31:0] log4_at(input int idx);
      return (idx < log4_q.size()) ? 32'(log4_q[idx]) : 32'hFFFF_FFFF;
   endfunction

   // driver: inputs are set by the caller in the low phase; this checks, logs,
   // advances the model for the coming edge and returns at the next negedge.
   task automatic tick();
      logic [3:0] cur;
      bit         mv, push, pop, dropped;
      #1;
      mv = (exp_q.size() > 0);
      if (armed) begin
         check("x_o", 32'(x), 32'(a | b | c));
         check("evt_valid", 32'(valid), 32'(mv));
         if (mv) check("evt_data", 32'(data), 32'(exp_q[0]));
         else    check("evt_data_idle", 32'(data), 32'h0);
         check("drop_cnt", 32'(drop_cnt), 32'(m_drops));
         check("overflow", 32'(overflow), 32'(m_ovf));
      end
      if (valid === 1'b1 && ready)   log_q.push_back(data);
      if (valid4 === 1'b1 && ready4) log4_q.push_back(data4);
      if (rst) begin
         exp_q.delete();
         m_ts = 0; m_prev = '0; m_first = 1'b1; m_drops = 0; m_ovf = 1'b0;
         armed = 1'b1;
      end else begin
         cur     = {a, b, c, a | b | c};
         push    = m_first || (cur != m_prev);
         pop     = mv && ready;
         dropped = push && (exp_q.size() == DEPTH) && !pop;
         if (dropped) begin
            if (m_drops < 255) m_drops++;
            m_ovf = 1'b1;
         end
         if (pop) void'(exp_q.pop_front());
         if (push && !dropped) exp_q.push_back(mk(m_ts, a, b, c));
         m_prev  = cur;
         m_first = 1'b0;
         m_ts    = (m_ts + 1) % (1 << TS_W);
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic run_to(input int t);
      int n = 0;
      while (m_ts != t && n < 70000) begin
         tick();
         n++;
      end
      if (m_ts != t) check("run_to_bound", 32'(m_ts), 32'(t));
   endtask

   initial begin
      @(negedge clk);

      // 1: reset, idle inputs -> single init record
      rst = 1'b1; ready = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      #1 check("t1_state_init", 32'(st), 32'(S_INIT));
      log_q.delete();
      tick();
      #1 check("t1_state_run", 32'(st), 32'(S_RUN));
      repeat (20) tick();
      check("t1_count", 32'(log_q.size()), 32'd1);
      check("t1_rec", log_at(0), 32'(mk(0, 0, 0, 0)));

      // 2: staggered rises at ts 10/20/30
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      log_q.delete();
      run_to(10);
      a = 1'b1;
      #1 check("t2_x_rise", 32'(x), 32'd1);
      tick();
      run_to(20); b = 1'b1; tick();
      run_to(30); c = 1'b1; tick();
      repeat (3) tick();
      check("t2_count", 32'(log_q.size()), 32'd4);
      check("t2_rec_a", log_at(1), 32'(mk(10, 1, 0, 0)));
      check("t2_rec_b", log_at(2), 32'(mk(20, 1, 1, 0)));
      check("t2_rec_c", log_at(3), 32'(mk(30, 1, 1, 1)));

      // 3: overflow with ready low
      a = 1'b0; b = 1'b0; c = 1'b0; ready = 1'b0;
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      tick();
      for (int i = 0; i < 5; i++) begin
         a = ~a;
         tick();
      end
      #1;
      check("t3_drop", 32'(drop_cnt), 32'd2);
      check("t3_ovf", 32'(overflow), 32'd1);
      log_q.delete();
      ready = 1'b1;
      repeat (4) tick();
      #1 check("t3_valid_after", 32'(valid), 32'd0);
      check("t3_count", 32'(log_q.size()), 32'd4);
      check("t3_rec0", log_at(0), 32'(mk(0, 0, 0, 0)));
      check("t3_rec1", log_at(1), 32'(mk(1, 1, 0, 0)));
      check("t3_rec2", log_at(2), 32'(mk(2, 0, 0, 0)));
      check("t3_rec3", log_at(3), 32'(mk(3, 1, 0, 0)));

      // 4: full FIFO, change plus pop in the same cycle
      ready = 1'b0;
      repeat (4) begin
         a = ~a;
         tick();
      end
      a = ~a; ready = 1'b1;
      tick();
      #1;
      check("t4_drop_same", 32'(drop_cnt), 32'd2);
      check("t4_count_full", 32'(dut.u_fifo.count), 32'(DEPTH));

      // 5: reset with records queued
      ready = 1'b1; tick();
      ready = 1'b0;
      #1 check("t5_queued", 32'(dut.u_fifo.count), 32'd3);
      rst = 1'b1; tick();
      rst = 1'b0;
      #1;
      check("t5_valid0", 32'(valid), 32'd0);
      check("t5_drop0", 32'(drop_cnt), 32'd0);
      check("t5_ovf0", 32'(overflow), 32'd0);
      log_q.delete();
      ready = 1'b1;
      repeat (2) tick();
      check("t5_fresh", log_at(0), 32'(mk(0, a, b, c)));

      // drop counter saturation
      ready = 1'b0;
      repeat (270) begin
         a = ~a;
         tick();
      end
      #1 check("sat_drop", 32'(drop_cnt), 32'd255);

      // random traffic against the model
      ready = 1'b1;
      rst = 1'b1; tick();
      rst = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         if ($urandom_range(0, 2) == 0) a = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 2) == 0) b = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 2) == 0) c = 1'($urandom_range(0, 1));
         ready = ($urandom_range(0, 3) != 0) || (i % 200 > 150) ? (i % 200 <= 150) : 1'b0;
         rst   = ($urandom_range(0, 299) == 0);
         tick();
      end
      rst = 1'b0;

      // 6: 4-bit timestamp wrap on the second instance
      log4_q.delete();
      rst4 = 1'b0; c4 = 1'b0;
      tick();
      repeat (14) tick();
      c4 = 1'b1;
      #1 check("t6_x_rise", 32'(x4), 32'd1);
      tick();
      c4 = 1'b0;
      tick();
      repeat (3) tick();
      check("t6_count", 32'(log4_q.size()), 32'd3);
      check("t6_init", log4_at(0), 32'(mk4(0, 1'b0)));
      check("t6_ts15", log4_at(1), 32'(mk4(15, 1'b1)));
      check("t6_wrap", log4_at(2), 32'(mk4(0, 1'b0)));
      check("t6_drop", 32'(drop4), 32'd0);

      // final report
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
